// File: rtl/osfm_fixed_divider.sv
// osfm_fixed_divider: sequential Q0.W restoring divider, q = floor(a*2^W/b) for a < b
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (a, b captured on accept)
//   a, b                dividend and divisor, Q0.W
//   out_valid/out_ready result handshake
//   q                   quotient, Q0.W
//   sat                 a >= b with b != 0, q saturated to all ones
//   div_zero            b == 0, q saturated to all ones
module osfm_fixed_divider #(
    parameter int BITWIDTH     = 8,
    parameter int APPROX_ITERS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BITWIDTH-1:0] a,
    input  logic [BITWIDTH-1:0] b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BITWIDTH-1:0] q,
    output logic                sat,
    output logic                div_zero
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    localparam int CW = $clog2(BITWIDTH + 1);
    localparam int CS = (APPROX_ITERS < BITWIDTH) ? BITWIDTH - 1 - APPROX_ITERS : 0;
    // Single compensation bit just below the last exactly computed quotient bit
    localparam logic [BITWIDTH-1:0] COMP = (APPROX_ITERS < BITWIDTH) ? BITWIDTH'(1) << CS : '0;

    state_t              r_state, w_state_n;
    logic [BITWIDTH:0]   r_rem, w_rem_d;
    logic [CW-1:0]       r_cnt, w_cnt_d;
    logic [BITWIDTH-1:0] r_b, w_b_d;
    logic [BITWIDTH-1:0] r_q, w_q_d;
    logic                r_sat, w_sat_d;
    logic                r_dz, w_dz_d;

    logic [BITWIDTH:0]   w_t, w_rem_it;
    logic [CW-1:0]       w_cnt_it;
    logic [BITWIDTH-1:0] w_bit, w_comp;
    logic                w_ge, w_last, w_exit;

    // Remainder stays below b, so the doubled value always fits in W+1 bits
    always_comb begin
        w_t      = r_rem << 1;
        w_ge     = w_t >= {1'b0, r_b};
        w_rem_it = w_ge ? w_t - {1'b0, r_b} : w_t;
        w_cnt_it = r_cnt + CW'(1);
        w_bit    = w_ge ? BITWIDTH'(1) << (CW'(BITWIDTH - 1) - r_cnt) : '0;
        w_last   = w_cnt_it == CW'(APPROX_ITERS);
        w_exit   = (w_rem_it == '0) || w_last;
        w_comp   = (w_last && (w_rem_it != '0)) ? COMP : '0;
    end

    always_comb begin
        w_state_n = r_state;
        w_rem_d   = r_rem;
        w_cnt_d   = r_cnt;
        w_b_d     = r_b;
        w_q_d     = r_q;
        w_sat_d   = r_sat;
        w_dz_d    = r_dz;
        case (r_state)
            IDLE: if (in_valid) begin
                w_b_d     = b;
                w_rem_d   = {1'b0, a};
                w_cnt_d   = '0;
                w_dz_d    = b == '0;
                w_sat_d   = (b != '0) && (a >= b);
                w_q_d     = (a >= b) ? '1 : '0;
                w_state_n = (a >= b || a == '0) ? DONE : CALC;
            end
            CALC: begin
                w_rem_d   = w_rem_it;
                w_cnt_d   = w_cnt_it;
                w_q_d     = r_q | w_bit | w_comp;
                w_state_n = w_exit ? DONE : CALC;
            end
            DONE:    w_state_n = out_ready ? IDLE : DONE;
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_b     <= '0;
            r_q     <= '0;
            r_sat   <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_rem   <= w_rem_d;
            r_cnt   <= w_cnt_d;
            r_b     <= w_b_d;
            r_q     <= w_q_d;
            r_sat   <= w_sat_d;
            r_dz    <= w_dz_d;
        end
    end

    assign in_ready  = r_state == IDLE;
    assign out_valid = r_state == DONE;
    assign q         = r_q;
    assign sat       = r_sat;
    assign div_zero  = r_dz;
endmodule

// File: tb/tb_osfm_fixed_divider.sv
// tb_osfm_fixed_divider: table, random and corner-sequence checks of an exact and a 4-iteration divider
module tb_osfm_fixed_divider;
    localparam int W = 8;
    localparam int K = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] a = '0, b = '0;
    logic         iv_e = 1'b0, iv_x = 1'b0, or_e = 1'b1, or_x = 1'b1;
    logic         ir_e, ir_x, ov_e, ov_x, sat_e, sat_x, dz_e, dz_x;
    logic [W-1:0] q_e, q_x;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    osfm_fixed_divider #(.BITWIDTH(W), .APPROX_ITERS(W)) u_exact (
        .clk(clk), .rst(rst), .in_valid(iv_e), .in_ready(ir_e), .a(a), .b(b),
        .out_valid(ov_e), .out_ready(or_e), .q(q_e), .sat(sat_e), .div_zero(dz_e));

    osfm_fixed_divider #(.BITWIDTH(W), .APPROX_ITERS(K)) u_apx (
        .clk(clk), .rst(rst), .in_valid(iv_x), .in_ready(ir_x), .a(a), .b(b),
        .out_valid(ov_x), .out_ready(or_x), .q(q_x), .sat(sat_x), .div_zero(dz_x));

    typedef struct {
        bit       apx;
        int       a, b;
        int       q;
        bit       sat, dz;
        int       n;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Long-division reference: k exact bits are floor(a*2^k/b); leftover remainder adds one bit below them
    task automatic model(input int k, input int ai, input int bi,
                         output int q, output bit s, output bit dz, output int n);
        longint num;
        s = 0; dz = 0; n = 0;
        if (bi == 0) begin q = (1 << W) - 1; dz = 1; end
        else if (ai >= bi) begin q = (1 << W) - 1; s = 1; end
        else if (ai == 0) q = 0;
        else begin
            num = longint'(ai) << k;
            q = int'((num / bi) << (W - k));
            if (k < W && num % bi != 0) q = q | (1 << (W - 1 - k));
            n = k;
            for (int i = 1; i <= k; i++)
                if (((longint'(ai) << i) % bi) == 0) begin n = i; break; end
        end
    endtask

    task automatic op(input bit sel, input int ai, input int bi,
                      output int q, output bit s, output bit dz, output int n);
        int guard = 0;
        while (!(sel ? ir_x : ir_e) && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        a = W'(ai); b = W'(bi);
        if (sel) iv_x = 1'b1; else iv_e = 1'b1;
        @(posedge clk); #1;
        iv_e = 1'b0; iv_x = 1'b0;
        a = ~a; b = ~b;
        n = 0;
        while (!(sel ? ov_x : ov_e) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        q  = sel ? int'(q_x) : int'(q_e);
        s  = sel ? sat_x : sat_e;
        dz = sel ? dz_x : dz_e;
    endtask

    vec_t tbl[12];

    initial begin
        int  q, n, mq, mn;
        bit  s, dz, ms, mdz;
        tbl[0]  = '{0, 1, 3, 'h55, 0, 0, 8};
        tbl[1]  = '{0, 64, 128, 'h80, 0, 0, 1};
        tbl[2]  = '{0, 200, 100, 'hFF, 1, 0, 0};
        tbl[3]  = '{0, 5, 0, 'hFF, 0, 1, 0};
        tbl[4]  = '{0, 0, 5, 'h00, 0, 0, 0};
        tbl[5]  = '{0, 255, 255, 'hFF, 1, 0, 0};
        tbl[6]  = '{0, 3, 4, 'hC0, 0, 0, 2};
        tbl[7]  = '{0, 1, 255, 'h01, 0, 0, 8};
        tbl[8]  = '{1, 1, 3, 'h58, 0, 0, 4};
        tbl[9]  = '{1, 64, 128, 'h80, 0, 0, 1};
        tbl[10] = '{1, 1, 7, 'h28, 0, 0, 4};
        tbl[11] = '{1, 1, 16, 'h10, 0, 0, 4};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst in_ready", int'(ir_e), 1);
        chk("rst out_valid", int'(ov_e), 0);
        chk("rst q", int'(q_e), 0);
        chk("rst sat", int'(sat_e), 0);
        chk("rst div_zero", int'(dz_e), 0);

        foreach (tbl[i]) begin
            op(tbl[i].apx, tbl[i].a, tbl[i].b, q, s, dz, n);
            chk($sformatf("tbl%0d q", i), q, tbl[i].q);
            chk($sformatf("tbl%0d sat", i), int'(s), int'(tbl[i].sat));
            chk($sformatf("tbl%0d dz", i), int'(dz), int'(tbl[i].dz));
            chk($sformatf("tbl%0d lat", i), n, tbl[i].n);
        end

        for (int i = 0; i < 60; i++) begin
            bit sel = i[0];
            int bi = int'($urandom_range(0, 255));
            int ai = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255))
                                                 : ((bi > 0) ? int'($urandom_range(0, bi - 1)) : 0);
            model(sel ? K : W, ai, bi, mq, ms, mdz, mn);
            op(sel, ai, bi, q, s, dz, n);
            chk($sformatf("rnd%0d q a=%0d b=%0d", i, ai, bi), q, mq);
            chk($sformatf("rnd%0d sat", i), int'(s), int'(ms));
            chk($sformatf("rnd%0d dz", i), int'(dz), int'(mdz));
            chk($sformatf("rnd%0d lat", i), n, mn);
        end

        @(posedge clk); #1;
        or_e = 1'b0;
        op(0, 1, 3, q, s, dz, n);
        chk("bp q", q, 'h55);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk($sformatf("bp%0d q", i), int'(q_e), 'h55);
            chk($sformatf("bp%0d out_valid", i), int'(ov_e), 1);
            chk($sformatf("bp%0d in_ready", i), int'(ir_e), 0);
        end
        or_e = 1'b1;
        @(posedge clk); #1;
        chk("bp release out_valid", int'(ov_e), 0);
        chk("bp release in_ready", int'(ir_e), 1);
        chk("bp release q kept", int'(q_e), 'h55);

        a = 8'd1; b = 8'd3; iv_e = 1'b1;
        @(posedge clk); #1;
        iv_e = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort out_valid", int'(ov_e), 0);
        chk("abort in_ready", int'(ir_e), 1);
        chk("abort q", int'(q_e), 0);
        op(0, 2, 3, q, s, dz, n);
        chk("after abort q", q, 'hAA);
        chk("after abort lat", n, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
